// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory stage.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    HALT   = 2'b10
  } mem_state_t;

  localparam logic [1:0] REG_SRC_ALU = 2'b00;
  localparam logic [1:0] REG_SRC_MEM = 2'b01;
  localparam logic [1:0] REG_SRC_PC4 = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and byte/word accesses:
// byte-enable generation, store-data replication and load byte extraction.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_word,
  input  logic [31:0] store_data,
  input  logic [31:0] load_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] load_byte_s;

  // Pick the little-endian lane addressed by the low address bits.
  always_comb begin
    load_byte_s = 8'h00;
    case (addr_lo)
      2'd0:    load_byte_s = load_rdata[7:0];
      2'd1:    load_byte_s = load_rdata[15:8];
      2'd2:    load_byte_s = load_rdata[23:16];
      2'd3:    load_byte_s = load_rdata[31:24];
      default: load_byte_s = 8'h00;
    endcase
  end

  // Word accesses use the whole bus; byte accesses enable one lane,
  // replicate the store byte everywhere and sign-extend the loaded byte.
  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0000_0000;
    load_data = 32'h0000_0000;
    if (is_word) begin
      be        = 4'b1111;
      wdata     = store_data;
      load_data = load_rdata;
    end else begin
      be        = 4'b0001 << addr_lo;
      wdata     = {4{store_data[7:0]}};
      load_data = {{24{load_byte_s[7]}}, load_byte_s};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts one instruction from EX, runs loads/stores over a
// req/ack handshake, stalls upstream while busy and registers the write-back.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [DATA_W-1:0] ex_pc4,
  input  logic [4:0]        ex_rd_num,
  input  logic              ex_register_write,
  input  logic [1:0]        ex_register_src,
  input  logic              ex_we_memory,
  input  logic              ex_is_word,
  input  logic              ex_halted,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_register_write,
  output logic [4:0]        wb_rd_num,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted
);

  mem_state_t        state_q, state_d;
  logic              stall_q, stall_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_rw_q, wb_rw_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              halted_q, halted_d;
  // Fields of the outstanding memory op needed when the ack arrives.
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic              cap_rw_q, cap_rw_d;
  logic              cap_we_q, cap_we_d;
  logic              cap_is_word_q, cap_is_word_d;
  logic [1:0]        cap_addr_lo_q, cap_addr_lo_d;

  logic              is_mem_s;
  logic [1:0]        align_addr_lo_s;
  logic              align_is_word_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       load_data_s;
  logic [DATA_W-1:0] nonmem_data_s;

  // In IDLE the aligner sees the incoming op (store side); in ACCESS it sees
  // the captured op so the returning read data is extracted correctly.
  always_comb begin
    if (state_q == ACCESS) begin
      align_addr_lo_s = cap_addr_lo_q;
      align_is_word_s = cap_is_word_q;
    end else begin
      align_addr_lo_s = ex_alu_result[1:0];
      align_is_word_s = ex_is_word;
    end
  end

  mem_lane_align u_align (
    .addr_lo    (align_addr_lo_s),
    .is_word    (align_is_word_s),
    .store_data (ex_rt_data),
    .load_rdata (mem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  // Classify the incoming op and select its non-memory result.
  always_comb begin
    is_mem_s = ex_we_memory | (ex_register_src == REG_SRC_MEM);
    if (ex_register_src == REG_SRC_PC4) begin
      nonmem_data_s = ex_pc4;
    end else begin
      nonmem_data_s = ex_alu_result;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack in ACCESS, park in HALT.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    wb_valid_d    = 1'b0;
    wb_rw_d       = wb_rw_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    halted_d      = halted_q;
    cap_rd_d      = cap_rd_q;
    cap_rw_d      = cap_rw_q;
    cap_we_d      = cap_we_q;
    cap_is_word_d = cap_is_word_q;
    cap_addr_lo_d = cap_addr_lo_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_halted) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = 1'b0;
            wb_rd_d    = ex_rd_num;
            wb_data_d  = nonmem_data_s;
            halted_d   = 1'b1;
            state_d    = HALT;
          end else if (is_mem_s) begin
            cap_rd_d      = ex_rd_num;
            cap_rw_d      = ex_register_write;
            cap_we_d      = ex_we_memory;
            cap_is_word_d = ex_is_word;
            cap_addr_lo_d = ex_alu_result[1:0];
            mem_req_d     = 1'b1;
            mem_we_d      = ex_we_memory;
            mem_addr_d    = {ex_alu_result[DATA_W-1:2], 2'b00};
            mem_wdata_d   = wdata_s;
            mem_be_d      = be_s;
            state_d       = ACCESS;
          end else begin
            wb_valid_d = 1'b1;
            wb_rw_d    = ex_register_write;
            wb_rd_d    = ex_rd_num;
            wb_data_d  = nonmem_data_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = cap_rd_q;
          state_d    = IDLE;
          if (cap_we_q) begin
            wb_rw_d = 1'b0;
          end else begin
            wb_rw_d   = cap_rw_q;
            wb_data_d = load_data_s;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall_d = (state_d != IDLE);
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stall_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 4'b0000;
      wb_valid_q    <= 1'b0;
      wb_rw_q       <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
      halted_q      <= 1'b0;
      cap_rd_q      <= 5'd0;
      cap_rw_q      <= 1'b0;
      cap_we_q      <= 1'b0;
      cap_is_word_q <= 1'b0;
      cap_addr_lo_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_rw_q       <= wb_rw_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      halted_q      <= halted_d;
      cap_rd_q      <= cap_rd_d;
      cap_rw_q      <= cap_rw_d;
      cap_we_q      <= cap_we_d;
      cap_is_word_q <= cap_is_word_d;
      cap_addr_lo_q <= cap_addr_lo_d;
    end
  end

  assign stall             = stall_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_be            = mem_be_q;
  assign wb_valid          = wb_valid_q;
  assign wb_register_write = wb_rw_q;
  assign wb_rd_num         = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign halted            = halted_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, consuming everything the execute stage produces each cycle. It performs loads and stores against the data memory over a req/ack handshake, stalls the upstream stages while an access is outstanding, and presents one registered write-back result per retired instruction. It also carries the halt indication through to the write-back stage.

## Interface
- `DATA_W`, 32: data and address width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  the EX outputs hold a live instruction
- `ex_alu_result`  in  32  ALU result, also the effective address for memory ops
- `ex_rt_data`  in  32  store data
- `ex_pc4`  in  32  PC+4, the link value
- `ex_rd_num`  in  5  destination register
- `ex_register_write`  in  1  instruction writes the register file
- `ex_register_src`  in  2  00 selects ALU, 01 selects memory, 10 selects PC+4
- `ex_we_memory`  in  1  store
- `ex_is_word`  in  1  1 means word access, 0 means byte access
- `ex_halted`  in  1  halt instruction
- `stall`  out  1  upstream stages hold their state
- `mem_req`  out  1  memory request
- `mem_we`  out  1  request is a write
- `mem_addr`  out  32  word-aligned address
- `mem_wdata`  out  32  write data
- `mem_be`  out  4  byte enables
- `mem_ack`  in  1  request completes this cycle
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_register_write`  out  1  write-enable to the register file, qualified by `wb_valid`
- `wb_rd_num`  out  5  destination register
- `wb_data`  out  32  write-back value
- `halted`  out  1  sticky halt flag

## Operation
- The state machine has three states: IDLE, ACCESS and HALT. The reset state is IDLE.
- In IDLE, the block accepts an instruction when `ex_valid` is high. Nothing is accepted outside IDLE.
- An instruction is a memory op when `ex_we_memory` = 1 or `ex_register_src` = 01.
- Accepting a non-memory op:
  - On the next edge, `wb_valid` = 1 for one cycle.
  - `wb_data` is the ALU result for source 00 and PC+4 for source 10.
  - The FSM stays in IDLE.
- Accepting a memory op:
  - All fields are captured and the FSM moves to ACCESS.
- In ACCESS, the following are held stable until the edge that samples `mem_ack` = 1:
  - `mem_req` = 1.
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_we` = the store flag.
- On ack, the FSM returns to IDLE and pulses `wb_valid` on that edge:
  - Store: `wb_register_write` = 0.
  - Word load: `wb_data` = `mem_rdata`.
  - Byte load: the lane selected by addr[1:0] (little-endian), sign-extended to 32 bits.
- Word access:
  - addr[1:0] is ignored and the access is forced aligned.
  - `mem_be` = 1111.
- Byte access:
  - `mem_be` = 0001 << addr[1:0].
  - `mem_wdata` = rt[7:0] replicated into all four lanes.
- `stall` = (state != IDLE). It is a registered state decode, so the instruction following an accepted memory op is held in EX.
- Halt:
  - An accepted `ex_halted` instruction retires like a non-memory op with `wb_register_write` = 0.
  - `halted` is set on the same edge and the FSM enters HALT.
  - In HALT, `stall` = 1, `ex_valid` is ignored, and only reset exits.
- `ex_register_write` is passed to `wb_register_write` unchanged for all non-store instructions.

## Timing
- Reset values: state IDLE, and every output is 0, including `mem_req`, `mem_be`, `wb_*`, `stall` and `halted`. Reset asserted mid-ACCESS drops `mem_req` immediately.
- Non-memory latency: 1 cycle from the accept edge to `wb_valid`.
- Memory latency: 2 cycles minimum, when `mem_ack` is high in the first ACCESS cycle. Each extra wait cycle adds 1.
- `mem_ack` is ignored outside ACCESS.
- `wb_valid` is never high in two consecutive cycles for memory ops. Back-to-back non-memory ops retire every cycle.
- `wb_*` outputs hold their last values when `wb_valid` = 0.

## Structure
- Shared package `mips_pkg`:
  - `mem_state_t` enum (IDLE, ACCESS, HALT).
  - Constants `REG_SRC_ALU` = 2'b00, `REG_SRC_MEM` = 2'b01, `REG_SRC_PC4` = 2'b10.
- One sub-module, `mem_lane_align`, which is combinational and contains:
  - Byte-enable generation.
  - Store-data replication.
  - Load byte extraction and sign extension.
- The FSM, capture registers and write-back registers are in `mem_stage`.

## Test plan
- ALU op: ALU result 0x0000_0042, rd 8, source 00 → `wb_valid` next cycle, `wb_data` 0x42, `wb_rd_num` 8, `stall` stays 0.
- Word load at 0x100, `mem_ack` after 3 wait cycles, rdata 0xDEAD_BEEF:
  - `mem_req` high for 4 cycles with `mem_addr` 0x100 and `mem_be` 1111.
  - `stall` high for 4 cycles.
  - `wb_data` 0xDEAD_BEEF.
- Byte load at 0x103 with rdata 0x80AA_BBCC → `mem_be` 1000, `wb_data` 0xFFFF_FF80. At 0x101 → `wb_data` 0xFFFF_FFBB.
- Byte store of rt 0x1234_5678 at 0x202 → `mem_addr` 0x200, `mem_be` 0100, `mem_wdata` 0x7878_7878, `mem_we` 1, `wb_register_write` 0.
- Jal-style op, source 10, PC+4 0x0040_0008, rd 31 → `wb_data` 0x0040_0008.
- Halt followed by an ALU op:
  - `halted` sticky, `stall` 1, and the ALU op never retires.
  - Reset asserted mid-ACCESS: all outputs 0 asynchronously, and the FSM restarts in IDLE.
